// File: rtl/fft_twiddle_mul.sv
// fft_twiddle_mul: stage-1 twiddle multiplier after the first DIF butterfly.
// Sum half passes through, difference half is multiplied by W512^n.
//
// Ports: clk, rstn (async, active low); din_re/din_im[NUM] + valid_in;
// dout_re/dout_im[NUM], valid_out, sof_out (2-cycle latency).
// Optional macro TWMUL_SAT_CNT_EN adds sat_cnt[15:0], a saturating count
// of clipped output components.
module fft_twiddle_mul #(
  parameter int NUM       = 16,
  parameter int FFT_N     = 512,
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 10,
  parameter int TW_WIDTH  = 9,
  parameter int TW_FRAC   = 7
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [IN_WIDTH-1:0]  din_re [0:NUM-1],
  input  logic signed [IN_WIDTH-1:0]  din_im [0:NUM-1],
  input  logic                        valid_in,
  output logic signed [OUT_WIDTH-1:0] dout_re [0:NUM-1],
  output logic signed [OUT_WIDTH-1:0] dout_im [0:NUM-1],
  output logic                        valid_out,
  output logic                        sof_out
`ifdef TWMUL_SAT_CNT_EN
  ,
  output logic [15:0]                 sat_cnt
`endif
);

  localparam int BEATS = FFT_N / NUM;
  localparam int BW    = $clog2(BEATS);
  localparam int LW    = $clog2(NUM);
  localparam int ROM_N = FFT_N / 2;
  localparam int IW    = $clog2(ROM_N);
  localparam int PW    = IN_WIDTH + TW_WIDTH;
  localparam int SW    = PW + 1;

  localparam longint PI_Q30 = 64'sd3373259426;
  localparam longint ONE_Q  = 64'sd1 <<< 30;
  localparam longint RND_Q  = 64'sd1 <<< 29;

  localparam logic signed [SW-1:0] RND =
    SW'(1 <<< (TW_FRAC - 1));
  localparam logic signed [SW-1:0] OMAX =
    SW'((1 <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] OMIN = ~OMAX;

  // Elaboration-time twiddle: Q30 Taylor series on the first quadrant,
  // second quadrant folded by the pi/2 rotation. Returns {re, im}.
  function automatic logic [2*TW_WIDTH-1:0] tw_calc(input int n);
    longint th, th2, c, s, tc, ts, re, im;
    int m;
    bit up;
    up  = (n >= FFT_N / 4);
    m   = up ? n - FFT_N / 4 : n;
    th  = (PI_Q30 * 2 * longint'(m)) / longint'(FFT_N);
    th2 = (th * th) >>> 30;
    c   = ONE_Q;
    s   = th;
    tc  = ONE_Q;
    ts  = th;
    for (int k = 1; k <= 10; k++) begin
      tc = -(((tc * th2) >>> 30) / longint'(2 * k * (2 * k - 1)));
      ts = -(((ts * th2) >>> 30) / longint'(2 * k * (2 * k + 1)));
      c  = c + tc;
      s  = s + ts;
    end
    re = ((c <<< TW_FRAC) + RND_Q) >>> 30;
    im = (((-s) <<< TW_FRAC) + RND_Q) >>> 30;
    if (up)
      return {TW_WIDTH'(im), TW_WIDTH'(-re)};
    return {TW_WIDTH'(re), TW_WIDTH'(im)};
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat_f(
    input logic signed [SW-1:0] x
  );
    if (x > OMAX)
      return OMAX[OUT_WIDTH-1:0];
    if (x < OMIN)
      return OMIN[OUT_WIDTH-1:0];
    return x[OUT_WIDTH-1:0];
  endfunction

  logic signed [TW_WIDTH-1:0] rom_re [ROM_N];
  logic signed [TW_WIDTH-1:0] rom_im [ROM_N];

  for (genvar n = 0; n < ROM_N; n++) begin : g_rom
    localparam logic [2*TW_WIDTH-1:0] TW = tw_calc(n);
    assign rom_re[n] = TW[2*TW_WIDTH-1:TW_WIDTH];
    assign rom_im[n] = TW[TW_WIDTH-1:0];
  end

  logic [BW-1:0] beat;

  // A gap in valid_in aborts the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      beat <= '0;
    else if (valid_in)
      beat <= beat + BW'(1);
    else
      beat <= '0;
  end

  logic [IW-1:0]              idx  [NUM];
  logic signed [TW_WIDTH-1:0] tw_r [NUM];
  logic signed [TW_WIDTH-1:0] tw_i [NUM];
  logic signed [PW-1:0]       m_rr [NUM];
  logic signed [PW-1:0]       m_ii [NUM];
  logic signed [PW-1:0]       m_ri [NUM];
  logic signed [PW-1:0]       m_ir [NUM];

  // Idle beats feed zero products so dout stays clean until real data.
  always_comb begin
    for (int l = 0; l < NUM; l++) begin
      idx[l]  = beat[BW-1] ? {beat[BW-2:0], LW'(l)} : '0;
      tw_r[l] = rom_re[idx[l]];
      tw_i[l] = rom_im[idx[l]];
      m_rr[l] = '0;
      m_ii[l] = '0;
      m_ri[l] = '0;
      m_ir[l] = '0;
      if (valid_in) begin
        m_rr[l] = PW'(din_re[l]) * PW'(tw_r[l]);
        m_ii[l] = PW'(din_im[l]) * PW'(tw_i[l]);
        m_ri[l] = PW'(din_re[l]) * PW'(tw_i[l]);
        m_ir[l] = PW'(din_im[l]) * PW'(tw_r[l]);
      end
    end
  end

  logic signed [PW-1:0] p_rr [NUM];
  logic signed [PW-1:0] p_ii [NUM];
  logic signed [PW-1:0] p_ri [NUM];
  logic signed [PW-1:0] p_ir [NUM];
  logic                 v1;
  logic                 sof1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int l = 0; l < NUM; l++) begin
        p_rr[l] <= '0;
        p_ii[l] <= '0;
        p_ri[l] <= '0;
        p_ir[l] <= '0;
      end
      v1   <= 1'b0;
      sof1 <= 1'b0;
    end else begin
      for (int l = 0; l < NUM; l++) begin
        p_rr[l] <= m_rr[l];
        p_ii[l] <= m_ii[l];
        p_ri[l] <= m_ri[l];
        p_ir[l] <= m_ir[l];
      end
      v1   <= valid_in;
      sof1 <= valid_in && (beat == '0);
    end
  end

  logic signed [SW-1:0] r_re [NUM];
  logic signed [SW-1:0] r_im [NUM];

  // Round half-up: bias then arithmetic shift (floor).
  always_comb begin
    for (int l = 0; l < NUM; l++) begin
      r_re[l] = (SW'(p_rr[l]) - SW'(p_ii[l]) + RND) >>> TW_FRAC;
      r_im[l] = (SW'(p_ri[l]) + SW'(p_ir[l]) + RND) >>> TW_FRAC;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int l = 0; l < NUM; l++) begin
        dout_re[l] <= '0;
        dout_im[l] <= '0;
      end
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
    end else begin
      for (int l = 0; l < NUM; l++) begin
        dout_re[l] <= sat_f(r_re[l]);
        dout_im[l] <= sat_f(r_im[l]);
      end
      valid_out <= v1;
      sof_out   <= sof1;
    end
  end

`ifdef TWMUL_SAT_CNT_EN
  localparam int CW = $clog2(2 * NUM + 1);

  function automatic logic is_sat(input logic signed [SW-1:0] x);
    return (x > OMAX) || (x < OMIN);
  endfunction

  logic [CW-1:0] n_sat;
  logic [16:0]   cnt_sum;

  always_comb begin
    n_sat = '0;
    for (int l = 0; l < NUM; l++)
      n_sat = n_sat + CW'(is_sat(r_re[l])) + CW'(is_sat(r_im[l]));
    cnt_sum = {1'b0, sat_cnt} + 17'(n_sat);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sat_cnt <= '0;
    else if (v1)
      sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule
